// File: rtl/data_bus_interconnect.sv
// Core load/store port to N memory-mapped slaves: region decode, one outstanding access, fault tracking.
// Latency 2+ cycles mapped, 1 cycle unmapped; the core holds its request until core_ready, slaves stall via slv_ready.
module data_bus_interconnect #(
   parameter int                        N_SLAVES        = 2,
   parameter logic [N_SLAVES*32-1:0]    SLAVE_BASE      = {32'h0000_0100, 32'h0000_0000},
   parameter logic [N_SLAVES*8-1:0]     SLAVE_SIZE_LOG2 = {8'd8, 8'd8},
   parameter int                        TIMEOUT         = 16,
   parameter int                        FAULT_CNT_W     = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      core_req,
   input  logic                      core_we,
   input  logic [3:0]                core_be,
   input  logic [31:0]               core_addr,
   input  logic [31:0]               core_wdata,
   output logic [31:0]               core_rdata,
   output logic                      core_ready,
   output logic                      core_error,
   output logic [N_SLAVES-1:0]       slv_req,
   output logic                      slv_we,
   output logic [3:0]                slv_be,
   output logic [31:0]               slv_addr,
   output logic [31:0]               slv_wdata,
   input  logic [N_SLAVES*32-1:0]    slv_rdata,
   input  logic [N_SLAVES-1:0]       slv_ready,
   output logic [31:0]               fault_addr,
   output logic [FAULT_CNT_W-1:0]    fault_count
);

   localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     sel_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 any_hit;
   logic [SEL_W-1:0]     hit_idx;
   logic [N_SLAVES-1:0]  hit_onehot;
   logic                 sel_ready;
   logic [31:0]          sel_rdata;

   logic                 latch, start, finish, fin_err;
   logic [31:0]          fin_rdata;

   // Size 32 yields an all-zero mask, so that region matches every address.
   function automatic logic [31:0] region_mask(input logic [7:0] size_log2);
      logic [63:0] low;
      low = (64'd1 << size_log2) - 64'd1;
      return ~low[31:0];
   endfunction

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      any_hit    = 1'b0;
      hit_idx    = '0;
      hit_onehot = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((core_addr & region_mask(SLAVE_SIZE_LOG2[i*8 +: 8])) ==
             (SLAVE_BASE[i*32 +: 32] & region_mask(SLAVE_SIZE_LOG2[i*8 +: 8]))) begin
            any_hit       = 1'b1;
            hit_idx       = SEL_W'(i);
            hit_onehot    = '0;
            hit_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_ready = slv_ready[i];
            sel_rdata = slv_rdata[i*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      latch     = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      fin_err   = 1'b0;
      fin_rdata = '0;
      case (state_q)
         IDLE: begin
            if (core_req) begin
               latch = 1'b1;
               if (any_hit) begin
                  start   = 1'b1;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  finish  = 1'b1;
                  fin_err = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               finish    = 1'b1;
               fin_rdata = slv_we ? 32'd0 : sel_rdata;
               state_d   = RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LIM[CNT_W-1:0])) begin
               finish  = 1'b1;
               fin_err = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sel_q       <= '0;
         slv_req     <= '0;
         slv_we      <= 1'b0;
         slv_be      <= '0;
         slv_addr    <= '0;
         slv_wdata   <= '0;
         core_ready  <= 1'b0;
         core_error  <= 1'b0;
         core_rdata  <= '0;
         fault_addr  <= '0;
         fault_count <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         core_ready <= finish;
         core_error <= finish & fin_err;
         if (latch) begin
            slv_we    <= core_we;
            slv_be    <= core_be;
            slv_addr  <= core_addr;
            slv_wdata <= core_wdata;
         end
         if (start) begin
            sel_q   <= hit_idx;
            slv_req <= hit_onehot;
         end else if (finish) begin
            slv_req <= '0;
         end
         if (finish) begin
            core_rdata <= fin_rdata;
         end
         // A miss resolves in IDLE before slv_addr is loaded, so take the live address there.
         if (finish && fin_err) begin
            fault_addr <= (state_q == IDLE) ? core_addr : slv_addr;
            if (fault_count != '1) begin
               fault_count <= fault_count + FAULT_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_data_bus_interconnect.sv
module tb_data_bus_interconnect;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we;
   logic [3:0]  core_be;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_ready, core_error;
   logic [1:0]  slv_req, slv_ready;
   logic        slv_we;
   logic [3:0]  slv_be;
   logic [31:0] slv_addr, slv_wdata, fault_addr;
   logic [63:0] slv_rdata;
   logic [7:0]  fault_count;

   logic        s_core_req;
   logic [31:0] s_core_addr, s_core_rdata, s_slv_addr, s_slv_wdata, s_fault_addr;
   logic        s_core_ready, s_core_error, s_slv_we;
   logic [1:0]  s_slv_req;
   logic [3:0]  s_slv_be;
   logic [1:0]  s_fault_count;

   int          dly;
   logic [31:0] srd;
   int          req_cnt [2];

   int          n_checks = 0;
   int          n_pass   = 0;
   int          m_cnt    = 0;
   logic [31:0] m_faddr  = 32'd0;

   always #5 clk = ~clk;

   data_bus_interconnect u_dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_be(core_be),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
      .core_ready(core_ready), .core_error(core_error),
      .slv_req(slv_req), .slv_we(slv_we), .slv_be(slv_be), .slv_addr(slv_addr),
      .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
      .fault_addr(fault_addr), .fault_count(fault_count)
   );

   data_bus_interconnect #(.FAULT_CNT_W(2)) u_small (
      .clk(clk), .reset(reset),
      .core_req(s_core_req), .core_we(1'b0), .core_be(4'hF),
      .core_addr(s_core_addr), .core_wdata(32'd0), .core_rdata(s_core_rdata),
      .core_ready(s_core_ready), .core_error(s_core_error),
      .slv_req(s_slv_req), .slv_we(s_slv_we), .slv_be(s_slv_be), .slv_addr(s_slv_addr),
      .slv_wdata(s_slv_wdata), .slv_rdata(64'd0), .slv_ready(2'b00),
      .fault_addr(s_fault_addr), .fault_count(s_fault_count)
   );

   // Slave model: ready once its request has been high for dly cycles; dly >= 100 never answers.
   assign slv_rdata = {srd, srd};
   always_comb begin
      slv_ready = '0;
      for (int i = 0; i < 2; i++)
         slv_ready[i] = slv_req[i] && (dly < 100) && (req_cnt[i] >= dly);
   end
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         req_cnt[i] <= slv_req[i] ? req_cnt[i] + 1 : 0;
   end

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr, wdata, srd;
      int          dly;
      logic [1:0]  exp_req;
      int          exp_req_cyc, exp_lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } resp_t;

   resp_t sb[$];
   vec_t  vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      resp_t e, got;
      int    req_cyc;
      logic [1:0] req_seen;
      bit    done;
      dly = v.dly;
      srd = v.srd;
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
      sb.push_back(e);
      @(negedge clk);
      core_req = 1'b1; core_we = v.we; core_be = v.be;
      core_addr = v.addr; core_wdata = v.wdata;
      req_cyc = 0; req_seen = '0; done = 0;
      got.rdata = '0; got.err = 1'b0; got.lat = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if (slv_req != '0) begin
            req_cyc++;
            if (req_seen == '0) begin
               req_seen = slv_req;
               check("slv_addr", slv_addr, v.addr);
               check("slv_we", 32'(slv_we), 32'(v.we));
               check("slv_be", 32'(slv_be), 32'(v.be));
               check("slv_wdata", slv_wdata, v.wdata);
            end
         end
         if (core_ready) begin
            done = 1;
            got.lat = c; got.rdata = core_rdata; got.err = core_error;
            core_req = 1'b0;
         end
      end
      e = sb.pop_front();
      if (!done) begin
         check("response_wait", 32'd0, 32'd1);
         core_req = 1'b0;
      end else begin
         check("core_rdata", got.rdata, e.rdata);
         check("core_error", 32'(got.err), 32'(e.err));
         check("latency", 32'(got.lat), 32'(e.lat));
      end
      check("slv_req_onehot", 32'(req_seen), 32'(v.exp_req));
      check("slv_req_cycles", 32'(req_cyc), 32'(v.exp_req_cyc));
      @(negedge clk);
      check("core_ready_single", 32'(core_ready), 32'd0);
      if (v.exp_err) begin
         m_cnt++;
         m_faddr = v.addr;
      end
      check("fault_count", 32'(fault_count), 32'(m_cnt));
      check("fault_addr", fault_addr, m_faddr);
   endtask

   function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd, input int d,
                               input logic [1:0] ereq, input int ecyc, input int elat,
                               input logic [31:0] erd, input logic eerr);
      vec_t v;
      v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.srd = rd; v.dly = d;
      v.exp_req = ereq; v.exp_req_cyc = ecyc; v.exp_lat = elat;
      v.exp_rdata = erd; v.exp_err = eerr;
      return v;
   endfunction

   initial begin
      int seen;
      bit got_rdy;
      reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_be = '0;
      core_addr = '0; core_wdata = '0; s_core_req = 1'b0; s_core_addr = '0;
      dly = 0; srd = '0;

      //       we    be      addr          wdata         slave rdata   dly  req    cyc lat exp rdata     err
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 0,   2'b01, 1,  2,  32'hDEADBEEF, 1'b0));
      vecs.push_back(mk(1'b1, 4'h3, 32'h0000_0104, 32'h12345678, 32'hCAFEF00D, 0,   2'b10, 1,  2,  32'h0,        1'b0));
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_0300, 32'h0,        32'h0,        0,   2'b00, 0,  1,  32'h0,        1'b1));
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_01FC, 32'h0,        32'hA5A50001, 3,   2'b10, 4,  5,  32'hA5A50001, 1'b0));
      vecs.push_back(mk(1'b1, 4'hC, 32'h0000_00FC, 32'h55AA00FF, 32'h11112222, 1,   2'b01, 2,  3,  32'h0,        1'b0));
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_01F0, 32'h0,        32'h77777777, 100, 2'b10, 16, 17, 32'h0,        1'b1));
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_0180, 32'h0,        32'h0BADC0DE, 15,  2'b10, 16, 17, 32'h0BADC0DE, 1'b0));
      vecs.push_back(mk(1'b0, 4'hF, 32'h0000_0200, 32'h0,        32'h0,        0,   2'b00, 0,  1,  32'h0,        1'b1));

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_slv_req", 32'(slv_req), 32'd0);
      check("rst_core_ready", 32'(core_ready), 32'd0);
      check("rst_core_error", 32'(core_error), 32'd0);
      check("rst_core_rdata", core_rdata, 32'd0);
      check("rst_slv_addr", slv_addr, 32'd0);
      check("rst_fault_count", 32'(fault_count), 32'd0);
      check("rst_fault_addr", fault_addr, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during a stalled access: request must vanish with no response.
      dly = 100;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 32'h0000_01F0;
      repeat (3) @(negedge clk);
      check("stall_slv_req", 32'(slv_req), 32'h2);
      reset = 1'b1; core_req = 1'b0;
      @(negedge clk);
      check("abort_slv_req", 32'(slv_req), 32'd0);
      check("abort_core_ready", 32'(core_ready), 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (core_ready) seen++;
      end
      check("abort_no_response", 32'(seen), 32'd0);
      check("abort_fault_count", 32'(fault_count), 32'd0);
      check("abort_fault_addr", fault_addr, 32'd0);
      m_cnt = 0; m_faddr = '0;
      run_vec(mk(1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h13579BDF, 0, 2'b01, 1, 2, 32'h13579BDF, 1'b0));

      // Narrow fault counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_core_req = 1'b1; s_core_addr = 32'h0000_0300 + 32'(i * 4);
         got_rdy = 0;
         for (int c = 0; c < 10 && !got_rdy; c++) begin
            @(negedge clk);
            if (s_core_ready) got_rdy = 1;
         end
         s_core_req = 1'b0;
         check("small_ready", 32'(got_rdy), 32'd1);
         @(negedge clk);
         check("small_fault_count", 32'(s_fault_count), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      check("small_fault_addr", s_fault_addr, 32'h0000_0310);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_bus_interconnect.md
# data_bus_interconnect

Parametrised data-side interconnect between the RISC-V core's load/store port and N memory-mapped slaves (RAM, peripherals). It decodes the core address against per-slave regions and runs a single-outstanding-transaction handshake with each slave. It returns a registered response with an error flag for unmapped addresses and slave timeouts, and keeps a fault address and fault counter for software/debug.

## Interface
- N_SLAVES, 2 — number of slave channels (1..8).
- SLAVE_BASE, {32'h0000_0100, 32'h0000_0000} — N_SLAVES×32 flat vector; slice i = base of region i; must be aligned to its size.
- SLAVE_SIZE_LOG2, {8'd8, 8'd8} — N_SLAVES×8 flat vector; slice i = log2(bytes) of region i (2..32).
- TIMEOUT, 16 — max cycles waiting for slv_ready; 0 disables timeout.
- FAULT_CNT_W, 8 — fault counter width.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- core_req  in  1  core data request; held with all core_* inputs until core_ready.
- core_we  in  1  1 = store, 0 = load.
- core_be  in  4  byte enable map.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data.
- core_rdata  out  32  load data, valid while core_ready=1.
- core_ready  out  1  one-cycle response strobe.
- core_error  out  1  response is a fault; qualified by core_ready.
- slv_req  out  N_SLAVES  one-hot request, at most one bit set.
- slv_we, slv_be, slv_addr, slv_wdata  out  1/4/32/32  shared, registered copies of the accepted request.
- slv_rdata  in  N_SLAVES×32  per-slave read data, slice i for slave i.
- slv_ready  in  N_SLAVES  per-slave completion; may be combinational on slv_req.
- fault_addr  out  32  address of most recent faulting request.
- fault_count  out  FAULT_CNT_W  saturating fault count.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on core_req=1, latch we/be/addr/wdata. Decode: slave i hits when core_addr[31:S_i] == SLAVE_BASE_i[31:S_i], S_i = SLAVE_SIZE_LOG2_i. Lowest index wins on overlap.
  - Hit: set slv_req[i], clear timeout counter, go to ACCESS.
  - Miss: set error, core_rdata=0, go to RESP. No slv_req is issued.
- ACCESS: slv_req[sel] is held.
  - slv_ready[sel]=1: capture slv_rdata[sel] into core_rdata on loads (0 on stores), drop slv_req, error=0, go to RESP.
  - Otherwise the counter increments. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without slv_ready: drop slv_req, error=1, core_rdata=0, go to RESP.
- RESP: core_ready=1 for exactly one cycle, core_error valid, then IDLE. A new request is accepted no earlier than the IDLE cycle after RESP.
- Fault (miss or timeout):
  - fault_addr ← latched address on entry to RESP.
  - fault_count increments and saturates at 2^FAULT_CNT_W-1.
- slv_ready on non-selected channels, or outside ACCESS, is ignored.
- core_req dropping before core_ready is a protocol violation; the transaction still completes.

## Timing
- Reset (checked every edge, overrides any state):
  - State → IDLE; slv_req, core_ready, core_error, core_rdata, slv_we/be/addr/wdata, fault_addr, fault_count → 0.
  - Reset mid-ACCESS aborts the transfer: slv_req drops on the same edge, and no core_ready is issued.
- Mapped access, req seen at edge 0:
  - slv_req high from cycle 1.
  - slv_ready first seen at cycle k≥1 → core_ready at cycle k+1.
  - Minimum latency is 2 cycles.
- Unmapped access: core_ready + core_error at cycle 1.
- Timeout: slv_req is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); core_ready + core_error at cycle TIMEOUT+1.
- slv_ready in the same cycle the timeout limit is reached: success wins.
- All outputs are registered; there is no combinational path from core_* to slv_* or back.

## Test plan
- Load from SLAVE 0, addr 0x10, slave ready same cycle with rdata 0xDEADBEEF → slv_req=01 at cycle 1; core_ready=1, core_rdata=0xDEADBEEF, core_error=0 at cycle 2.
- Store to 0x104, be=4'b0011, wdata 0x1234_5678 → slv_req=10, slv_addr=0x104, slv_be=0011, slv_wdata=0x12345678; core_rdata=0 at the response.
- Load from unmapped 0x300 → core_ready and core_error at cycle 1; slv_req stays 0; fault_addr=0x300; fault_count=1.
- Slave 1 never ready, TIMEOUT=16 → slv_req high for exactly 16 cycles; error response at cycle 17; fault_count increments.
- Slave ready on the timeout-limit cycle (cycle 16) → success response, no fault recorded.
- Reset pulsed at cycle 3 of a stalled ACCESS → slv_req=0 after that edge; no core_ready; fault_count=0; next request is accepted normally.
- With FAULT_CNT_W=2, issue 5 unmapped accesses → fault_count reads 3.
